program_store: RTL and testbench
================================

# program_store

Parametrised, writable program memory for the 8-bit core, replacing the fixed in-source ROM image. It holds the instruction stream, serves a registered two-byte fetch (opcode byte plus following operand byte) to the core, and accepts a new program image at run time through a valid/ready load port driven by the host/UART bridge. The core is stalled by `fetch_valid` while a load is in progress.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 8: address width; depth is fixed at `2**ADDR_W` words (localparam `DEPTH`).

Ports:
- `program_clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  request a fetch at `fetch_addr`.
- `fetch_addr`  in  ADDR_W  fetch address.
- `fetch_data`  out  DATA_W  word at the fetch address.
- `fetch_data2`  out  DATA_W  word at `(fetch_addr+1) mod DEPTH`.
- `fetch_valid`  out  1  fetch data valid this cycle.
- `load_start`  in  1  one-cycle pulse that begins a load.
- `load_base`  in  ADDR_W  first address written, sampled on `load_start`.
- `load_len`  in  ADDR_W+1  number of words to write, sampled on `load_start`.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  DATA_W  word to write.
- `load_ready`  out  1  block accepts a word this cycle.
- `load_busy`  out  1  a load is in progress.
- `load_done`  out  1  one-cycle pulse at successful completion.
- `load_err`  out  1  one-cycle pulse when a load is rejected.
- `load_sum`  out  DATA_W  modulo-2^DATA_W sum of the words accepted in the current/last load.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `load_start` with `load_len == 0` goes to DONE. Nothing is written.
  - `load_start` with `load_base + load_len > DEPTH` pulses `load_err`, writes nothing and stays in IDLE.
  - Any other `load_start` latches the base into the write pointer, latches the length into a remaining counter, clears `load_sum` and goes to LOAD.
- LOAD:
  - `load_ready = 1` and `load_busy = 1`.
  - Each cycle with `load_valid & load_ready`: write `load_data` at the pointer, increment the pointer, decrement the counter, and add the word to `load_sum`.
  - Acceptance of the last word goes to DONE.
  - `load_start` is ignored while in LOAD.
- DONE: `load_done = 1` for exactly one cycle, then IDLE.
- Fetch:
  - Served only in IDLE.
  - A `fetch_en` in LOAD or DONE is dropped: no queueing, and `fetch_valid` stays 0.
  - The core re-issues the fetch after `load_busy` falls.
- Read-after-write: a fetch issued after a write cycle returns the new word.
- `fetch_data2` address arithmetic wraps modulo `DEPTH` (address 255 pairs with address 0 at `ADDR_W=8`).
- Reset:
  - Returns the FSM to IDLE and zeroes all outputs.
  - Memory contents are not cleared (array must infer block/distributed RAM).
  - Reset mid-load aborts the load: words already written stay written, and `load_done` is not pulsed.
- A write of the last address (`base + len == DEPTH`) is legal. The pointer wraps to 0 after it but is never used.

## Timing
- Fetch latency is 1 cycle. `fetch_en` sampled at edge t gives `fetch_data`, `fetch_data2` and `fetch_valid = 1` after edge t+1.
- `fetch_valid` is 0 in any cycle following a cycle without an accepted fetch. The data outputs hold their last value.
- `load_ready` is a registered state decode, with no combinational path from `load_valid`.
- Writes occur at the edge where `load_valid & load_ready`. One word per cycle is sustained.
- Minimum load of N words: `load_start` edge, then N accept edges, then 1 DONE cycle. `load_busy` falls one cycle after the last accept.
- `load_err` is asserted the cycle after the offending `load_start`.
- Reset values: `fetch_data`, `fetch_data2` and `load_sum` are 0. `fetch_valid`, `load_ready`, `load_busy`, `load_done` and `load_err` are 0.

## Structure
- Shared package `program_pkg`:
  - FSM state encoding (`PS_IDLE`, `PS_LOAD`, `PS_DONE`).
  - Opcode constants currently used by the program image (ADD, SUB, MUL, MOV, NOP, LD_IMM, CMP, DEC, INPUT, OUTPUT, BRA, BHI, BEQ).
  - Default `DATA_W`/`ADDR_W`.
- One sub-module, `program_ram`: simple dual-port RAM with one write port and two registered read ports. It holds no control logic.
- The FSM, counters and checksum live in `program_store`.

## Test plan
- Load 4 words `0x80,0x00,0x84,0x05` at base 0.
  - During the load: `load_ready` is high.
  - After the DONE cycle: `load_done` pulses once and `load_sum == 0x09`.
  - A fetch at 0 then gives `fetch_data = 0x80` and `fetch_data2 = 0x00` one cycle later.
- Load with `load_valid` toggling every other cycle for 3 words at base 10.
  - Only the asserted cycles write.
  - Fetches at 10, 11 and 12 return the words in order.
- Wrap fetch: load 2 words at base 254 (`0xAA`, `0xBB`) and 1 word at base 0 (`0xCC`).
  - A fetch at 255 gives `0xBB` and `0xCC`.
  - A fetch at 254 gives `0xAA` and `0xBB`.
- Rejects and ignored starts:
  - `load_start` with base 250 and len 7: `load_err` pulses next cycle, memory is unchanged and `load_busy` stays 0.
  - len 0: `load_done` pulses with no write.
- `fetch_en` held high during a load: `fetch_valid` stays 0 throughout LOAD and DONE, then returns to 1 one cycle after re-issue in IDLE.
- Reset asserted after 2 of 5 words:
  - All outputs are 0 on the next cycle, and there is no `load_done`.
  - Fetch shows the 2 written words present.
  - A new load starts cleanly with `load_sum` cleared.

Source files
------------

// File: rtl/program_pkg.sv
// Shared definitions for the writable program store of the 8-bit core:
// load FSM encoding, default geometry and opcodes used by the program image.
package program_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic [1:0] {
      PS_IDLE = 2'd0,
      PS_LOAD = 2'd1,
      PS_DONE = 2'd2
   } ps_state_e;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_ADD    = 8'h80;
   localparam logic [7:0] OP_SUB    = 8'h81;
   localparam logic [7:0] OP_MUL    = 8'h82;
   localparam logic [7:0] OP_MOV    = 8'h83;
   localparam logic [7:0] OP_LD_IMM = 8'h84;
   localparam logic [7:0] OP_CMP    = 8'h85;
   localparam logic [7:0] OP_DEC    = 8'h86;
   localparam logic [7:0] OP_INPUT  = 8'h87;
   localparam logic [7:0] OP_OUTPUT = 8'h88;
   localparam logic [7:0] OP_BRA    = 8'h89;
   localparam logic [7:0] OP_BHI    = 8'h8A;
   localparam logic [7:0] OP_BEQ    = 8'h8B;

endpackage

// File: rtl/program_ram.sv
// Simple dual-port program RAM: one write port, two registered read ports.
// Only the read registers are reset; the array itself is never cleared.
module program_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_a_q;
   logic [DATA_W-1:0] rd_b_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else if (re) begin
         rd_a_q <= mem[raddr_a];
         rd_b_q <= mem[raddr_b];
      end
   end

   assign rdata_a = rd_a_q;
   assign rdata_b = rd_b_q;

endmodule

// File: rtl/program_store.sv
// Writable program memory: registered two-byte fetch for the core and a
// valid/ready image load port with length check and running checksum.
module program_store
   import program_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              program_clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic [DATA_W-1:0] fetch_data2,
   output logic              fetch_valid,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_len,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic [DATA_W-1:0] load_sum
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

   ps_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              err_q, err_d;
   logic              fvalid_q, fvalid_d;
   logic              we;
   logic              re;
   logic [ADDR_W+1:0] end_addr;
   logic              too_long;

   // Two extra bits so base+len never wraps before the range check.
   assign end_addr = {2'b00, load_base} + {1'b0, load_len};
   assign too_long = end_addr > DEPTH_W;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      sum_d   = sum_q;
      err_d   = 1'b0;
      we      = 1'b0;
      unique case (state_q)
         PS_IDLE: begin
            if (load_start) begin
               if (load_len == '0) begin
                  state_d = PS_DONE;
               end else if (too_long) begin
                  err_d = 1'b1;
               end else begin
                  ptr_d   = load_base;
                  rem_d   = load_len;
                  sum_d   = '0;
                  state_d = PS_LOAD;
               end
            end
         end
         PS_LOAD: begin
            if (load_valid) begin
               we    = 1'b1;
               ptr_d = ptr_q + ADDR_W'(1);
               rem_d = rem_q - (ADDR_W+1)'(1);
               sum_d = sum_q + load_data;
               if (rem_q == (ADDR_W+1)'(1)) begin
                  state_d = PS_DONE;
               end
            end
         end
         PS_DONE: begin
            state_d = PS_IDLE;
         end
         default: begin
            state_d = PS_IDLE;
         end
      endcase
   end

   assign re       = fetch_en & (state_q == PS_IDLE);
   assign fvalid_d = re;

   always_ff @(posedge program_clk) begin
      if (reset) begin
         state_q  <= PS_IDLE;
         ptr_q    <= '0;
         rem_q    <= '0;
         sum_q    <= '0;
         err_q    <= 1'b0;
         fvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         rem_q    <= rem_d;
         sum_q    <= sum_d;
         err_q    <= err_d;
         fvalid_q <= fvalid_d;
      end
   end

   program_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (program_clk),
      .rst     (reset),
      .we      (we),
      .waddr   (ptr_q),
      .wdata   (load_data),
      .re      (re),
      .raddr_a (fetch_addr),
      .raddr_b (fetch_addr + ADDR_W'(1)),
      .rdata_a (fetch_data),
      .rdata_b (fetch_data2)
   );

   assign fetch_valid = fvalid_q;
   assign load_ready  = (state_q == PS_LOAD);
   assign load_busy   = (state_q != PS_IDLE);
   assign load_done   = (state_q == PS_DONE);
   assign load_err    = err_q;
   assign load_sum    = sum_q;

endmodule

// File: tb/tb_program_store.sv
// Directed self-checking bench for program_store: loads, wrap fetch,
// rejects, fetch drop during load and reset mid-load.
module tb_program_store;

   logic       program_clk = 1'b0;
   logic       reset;
   logic       fetch_en;
   logic [7:0] fetch_addr;
   logic [7:0] fetch_data;
   logic [7:0] fetch_data2;
   logic       fetch_valid;
   logic       load_start;
   logic [7:0] load_base;
   logic [8:0] load_len;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic       load_busy;
   logic       load_done;
   logic       load_err;
   logic [7:0] load_sum;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 program_clk = ~program_clk;

   program_store #(
      .DATA_W (8),
      .ADDR_W (8)
   ) dut (
      .program_clk (program_clk),
      .reset       (reset),
      .fetch_en    (fetch_en),
      .fetch_addr  (fetch_addr),
      .fetch_data  (fetch_data),
      .fetch_data2 (fetch_data2),
      .fetch_valid (fetch_valid),
      .load_start  (load_start),
      .load_base   (load_base),
      .load_len    (load_len),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_busy   (load_busy),
      .load_done   (load_done),
      .load_err    (load_err),
      .load_sum    (load_sum)
   );

   task automatic step();
      @(posedge program_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [7:0] base, input logic [8:0] len);
      load_start = 1'b1;
      load_base  = base;
      load_len   = len;
      step();
      load_start = 1'b0;
   endtask

   task automatic put(input logic [7:0] d);
      load_valid = 1'b1;
      load_data  = d;
      step();
      load_valid = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic [7:0] a,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input bit chk2);
      fetch_en   = 1'b1;
      fetch_addr = a;
      step();
      fetch_en = 1'b0;
      check({tag, "_valid"}, 16'(fetch_valid), 16'h1);
      check({tag, "_d1"}, 16'(fetch_data), 16'(e1));
      if (chk2) check({tag, "_d2"}, 16'(fetch_data2), 16'(e2));
   endtask

   task automatic all_zero(input string tag);
      check({tag, "_fd"}, 16'(fetch_data), 16'h0);
      check({tag, "_fd2"}, 16'(fetch_data2), 16'h0);
      check({tag, "_fv"}, 16'(fetch_valid), 16'h0);
      check({tag, "_rdy"}, 16'(load_ready), 16'h0);
      check({tag, "_busy"}, 16'(load_busy), 16'h0);
      check({tag, "_done"}, 16'(load_done), 16'h0);
      check({tag, "_err"}, 16'(load_err), 16'h0);
      check({tag, "_sum"}, 16'(load_sum), 16'h0);
   endtask

   initial begin
      reset      = 1'b1;
      fetch_en   = 1'b0;
      fetch_addr = '0;
      load_start = 1'b0;
      load_base  = '0;
      load_len   = '0;
      load_valid = 1'b0;
      load_data  = '0;
      step();
      step();
      reset = 1'b0;
      all_zero("rst");

      // 4-word load at base 0
      start(8'd0, 9'd4);
      check("l1_rdy", 16'(load_ready), 16'h1);
      check("l1_busy", 16'(load_busy), 16'h1);
      put(8'h80);
      check("l1_rdy_mid", 16'(load_ready), 16'h1);
      put(8'h00);
      put(8'h84);
      put(8'h05);
      check("l1_done", 16'(load_done), 16'h1);
      check("l1_sum", 16'(load_sum), 16'h09);
      check("l1_rdy_done", 16'(load_ready), 16'h0);
      step();
      check("l1_done_off", 16'(load_done), 16'h0);
      check("l1_busy_off", 16'(load_busy), 16'h0);
      fetch("f0", 8'd0, 8'h80, 8'h00, 1'b1);
      step();
      check("f0_valid_drop", 16'(fetch_valid), 16'h0);
      check("f0_hold", 16'(fetch_data), 16'h80);

      // valid toggling every other cycle
      start(8'd10, 9'd3);
      load_data = 8'hEE;
      step();
      put(8'h11);
      load_data = 8'hEE;
      step();
      put(8'h22);
      load_data = 8'hEE;
      step();
      check("t_not_done", 16'(load_done), 16'h0);
      put(8'h33);
      check("t_done", 16'(load_done), 16'h1);
      check("t_sum", 16'(load_sum), 16'h66);
      step();
      fetch("f10", 8'd10, 8'h11, 8'h22, 1'b1);
      fetch("f11", 8'd11, 8'h22, 8'h33, 1'b1);
      fetch("f12", 8'd12, 8'h33, 8'h00, 1'b0);

      // wrap: 254..255 then 0
      start(8'd254, 9'd2);
      put(8'hAA);
      put(8'hBB);
      check("w1_done", 16'(load_done), 16'h1);
      step();
      start(8'd0, 9'd1);
      put(8'hCC);
      check("w2_done", 16'(load_done), 16'h1);
      step();
      fetch("f255", 8'd255, 8'hBB, 8'hCC, 1'b1);
      fetch("f254", 8'd254, 8'hAA, 8'hBB, 1'b1);

      // reject 250+7 > 256
      start(8'd250, 9'd7);
      check("rej_err", 16'(load_err), 16'h1);
      check("rej_busy", 16'(load_busy), 16'h0);
      check("rej_rdy", 16'(load_ready), 16'h0);
      load_valid = 1'b1;
      load_data  = 8'h5A;
      step();
      load_valid = 1'b0;
      check("rej_err_off", 16'(load_err), 16'h0);
      check("rej_busy2", 16'(load_busy), 16'h0);
      fetch("rej_mem", 8'd254, 8'hAA, 8'hBB, 1'b1);

      // reject 255+2, one past the end
      start(8'd255, 9'd2);
      check("rej2_err", 16'(load_err), 16'h1);
      step();

      // zero length goes straight to DONE
      start(8'd0, 9'd0);
      check("z_done", 16'(load_done), 16'h1);
      check("z_rdy", 16'(load_ready), 16'h0);
      step();
      check("z_done_off", 16'(load_done), 16'h0);
      fetch("z_mem", 8'd0, 8'hCC, 8'h00, 1'b0);

      // fetch held through a load is dropped
      start(8'd20, 9'd2);
      fetch_en   = 1'b1;
      fetch_addr = 8'd10;
      load_valid = 1'b1;
      load_data  = 8'h01;
      step();
      check("h_fv_load1", 16'(fetch_valid), 16'h0);
      load_data = 8'h02;
      step();
      load_valid = 1'b0;
      check("h_fv_done", 16'(fetch_valid), 16'h0);
      check("h_done", 16'(load_done), 16'h1);
      step();
      check("h_fv_idle0", 16'(fetch_valid), 16'h0);
      check("h_busy_off", 16'(load_busy), 16'h0);
      step();
      check("h_fv_back", 16'(fetch_valid), 16'h1);
      check("h_fd", 16'(fetch_data), 16'h11);
      fetch_en = 1'b0;
      step();

      // reset after 2 of 5 words
      start(8'd30, 9'd5);
      put(8'h01);
      put(8'h02);
      reset      = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h03;
      step();
      reset      = 1'b0;
      load_valid = 1'b0;
      all_zero("mrst");
      step();
      check("mrst_nodone", 16'(load_done), 16'h0);
      check("mrst_idle", 16'(load_busy), 16'h0);
      fetch("mrst_mem", 8'd30, 8'h01, 8'h02, 1'b1);
      start(8'd40, 9'd1);
      check("n_sum_clr", 16'(load_sum), 16'h00);
      put(8'h07);
      check("n_done", 16'(load_done), 16'h1);
      check("n_sum", 16'(load_sum), 16'h07);
      step();
      fetch("f40", 8'd40, 8'h07, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
